// File: rtl/layernorm_mean_var_pkg.sv
// Shared constants, FSM encoding and accumulator sizing for the LayerNorm
// statistics datapath.
package layernorm_pkg;

    localparam int FRAC_BITS_IN    = 10;
    localparam int FRAC_BITS_RAD   = 20;
    localparam int FRAC_BITS_OUT   = 10;
    localparam int EPSILON_DEFAULT = 11;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_MEAN  = 2'd1,
        ST_VAR   = 2'd2,
        ST_EMIT  = 2'd3
    } ln_state_e;

    function automatic int sum_width(input int data_w, input int log2_len);
        return data_w + log2_len;
    endfunction

    function automatic int sumsq_width(input int data_w, input int log2_len);
        return 2 * data_w + log2_len;
    endfunction

endpackage

// File: rtl/ln_square_accum.sv
// Signed squarer feeding the running sum and sum-of-squares registers.
// Both accumulators are sized so a full vector of full-scale samples cannot wrap.
module ln_square_accum
    import layernorm_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int LOG2_LEN   = 6,
    localparam int SUM_W     = sum_width(DATA_WIDTH, LOG2_LEN),
    localparam int SUMSQ_W   = sumsq_width(DATA_WIDTH, LOG2_LEN)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic signed [SUM_W-1:0]      sum,
    output logic        [SUMSQ_W-1:0]    sumsq
);

    localparam int SQ_W = 2 * DATA_WIDTH;

    logic signed [SQ_W-1:0] data_ext_p0;
    logic signed [SQ_W-1:0] sq_p0;

    assign data_ext_p0 = SQ_W'(in_data);
    assign sq_p0       = data_ext_p0 * data_ext_p0;

    // stage p0 -> accumulators; a square is never negative, so zero-extend it
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            sum   <= '0;
            sumsq <= '0;
        end else if (en) begin
            sum   <= sum + SUM_W'(in_data);
            sumsq <= sumsq + SUMSQ_W'($unsigned(sq_p0));
        end
    end

endmodule

// File: rtl/layernorm_mean_var.sv
// Streaming mean / variance+epsilon stage for LayerNorm. Emits the Q5.10 mean
// and a saturated Q4.20 radicand with a one-cycle valid pulse per vector.
module layernorm_mean_var #(
    parameter int DATA_WIDTH     = 16,
    parameter int FRAC_BITS_IN   = layernorm_pkg::FRAC_BITS_IN,
    parameter int VECTOR_LEN     = 64,
    parameter int LOG2_LEN       = 6,
    parameter int RADICAND_WIDTH = 24,
    parameter int EPSILON        = layernorm_pkg::EPSILON_DEFAULT
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic signed [DATA_WIDTH-1:0]     in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic signed [DATA_WIDTH-1:0]     mean_out,
    output logic        [RADICAND_WIDTH-1:0] radicand_out,
    output logic                             valid_out
);

    import layernorm_pkg::*;

    localparam int SUM_W   = sum_width(DATA_WIDTH, LOG2_LEN);
    localparam int SUMSQ_W = sumsq_width(DATA_WIDTH, LOG2_LEN);
    localparam int EX2_W   = SUMSQ_W - LOG2_LEN;
    localparam int DIFF_W  = EX2_W + 2;
    localparam logic signed [DIFF_W-1:0] RAD_LIMIT = DIFF_W'(1) << RADICAND_WIDTH;

    ln_state_e state, state_nxt;

    logic [LOG2_LEN-1:0]        cnt;
    logic                       xfer;
    logic                       last_xfer;
    logic signed [SUM_W-1:0]    sum;
    logic [SUMSQ_W-1:0]         sumsq;

    logic signed [DATA_WIDTH-1:0] mean_p1;
    logic [EX2_W-1:0]             ex2_p1;
    logic signed [EX2_W-1:0]      mean_ext_p1;
    logic signed [EX2_W-1:0]      msq_p1;
    logic signed [DIFF_W-1:0]     diff_p1;

    // Negative differences come from truncation in the two shifts; clamp them,
    // add epsilon, then pin anything beyond the radicand range to all ones.
    function automatic logic [RADICAND_WIDTH-1:0] sat_radicand(
        input logic signed [DIFF_W-1:0] d
    );
        logic signed [DIFF_W-1:0] r;
        r = (d < 0) ? '0 : d;
        r = r + DIFF_W'(EPSILON);
        if (r >= RAD_LIMIT)
            return '1;
        return RADICAND_WIDTH'(r);
    endfunction

    assign in_ready  = rst_n && (state == ST_ACCUM);
    assign xfer      = in_valid && in_ready;
    assign last_xfer = xfer && (cnt == LOG2_LEN'(VECTOR_LEN - 1));

    ln_square_accum #(
        .DATA_WIDTH (DATA_WIDTH),
        .LOG2_LEN   (LOG2_LEN)
    ) u_accum (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state == ST_EMIT),
        .en      (xfer),
        .in_data (in_data),
        .sum     (sum),
        .sumsq   (sumsq)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACCUM: if (last_xfer) state_nxt = ST_MEAN;
            ST_MEAN:  state_nxt = ST_VAR;
            ST_VAR:   state_nxt = ST_EMIT;
            ST_EMIT:  state_nxt = ST_ACCUM;
            default:  state_nxt = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || state == ST_EMIT) begin
            cnt <= '0;
        end else if (xfer) begin
            cnt <= cnt + 1'b1;
        end
    end

    // stage p1: divide by the vector length with shifts
    always_ff @(posedge clk) begin
        if (state == ST_MEAN) begin
            mean_p1 <= DATA_WIDTH'(sum >>> LOG2_LEN);
            ex2_p1  <= EX2_W'(sumsq >> LOG2_LEN);
        end
    end

    assign mean_ext_p1 = EX2_W'(mean_p1);
    assign msq_p1      = mean_ext_p1 * mean_ext_p1;
    assign diff_p1     = $signed({2'b00, ex2_p1}) - $signed({2'b00, msq_p1});

    // stage p2: registered results, held until the next vector completes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mean_out     <= '0;
            radicand_out <= '0;
            valid_out    <= 1'b0;
        end else begin
            valid_out <= (state == ST_VAR);
            if (state == ST_VAR) begin
                mean_out     <= mean_p1;
                radicand_out <= sat_radicand(diff_p1);
            end
        end
    end

endmodule
